// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared constants and types for the instruction-fetch slice:
//   - XLEN / ILEN         : address and instruction widths
//   - NOP_INSTR           : filler instruction placed in exception entries
//   - EXC_INSTR_*         : fetch exception cause codes
//   - fetch_entry_t       : one fetch-queue entry (pc, instr, exception info)
//   - fetch_state_t       : RUN / HALT state of the fetch FSM
// ----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] EXC_INSTR_ACCESS     = 4'd1;

   // 64 + 32 + 1 + 4 + 64 = 165 bits
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            exc_en;
      logic [3:0]      exc_code;
      logic [XLEN-1:0] exc_val;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // Instructions are 4-byte aligned; any low address bit set is a fault.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO holding fetched entries between the fetch stage and
// decode.
//   clk, rst    : clock and synchronous active-high reset
//   push        : write push_data at the tail (ignored if full and no pop)
//   push_data   : entry to enqueue
//   pop         : remove the head entry (ignored when empty)
//   flush       : discard all entries; wins over push, a same-cycle pop is
//                 simply absorbed by the flush
//   head_data   : entry at the head (meaningless when empty)
//   count       : number of stored entries
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 165
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0] ONE_CNT   = (PW+1)'(1);
   localparam logic [PW-1:0] ONE_PTR = PW'(1);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Qualify the raw requests: a push into a full queue is only legal when
   // the head leaves in the same cycle, and a flush suppresses the push.
   always_comb begin
      empty   = (count == '0);
      full    = (count == DEPTH_CNT);
      do_pop  = pop && !empty;
      do_push = push && !flush && (!full || do_pop);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ONE_PTR;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ONE_PTR;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + ONE_CNT;
            2'b01:   count <= count - ONE_CNT;
            default: count <= count;
         endcase
      end
   end

   // Entry storage has no reset; its contents only matter once count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         storage[wr_ptr] <= push_data;
      end
   end

   assign head_data = storage[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch initiator for a combinational instruction memory. Holds
// the PC, forms one tagged entry per fetch and buffers it in fetch_queue for
// decode. A redirect flushes the queue and restarts fetch at redirect_pc; a
// fetch exception enqueues one exception entry and halts fetch until the
// next redirect or reset.
//   clk, rst            : clock, synchronous active-high reset
//   pc_addr             : fetch address (PC register)
//   instruction         : word returned by memory for pc_addr
//   exc_en/code/val     : memory fetch exception for pc_addr
//   redirect_en/pc      : flush and restart fetch at redirect_pc
//   out_valid/ready     : handshake towards decode
//   out_pc/instr/exc_*  : head entry fields (all zero while the queue is empty)
//   fetch_halted        : fetch stopped after an exception entry
// ----------------------------------------------------------------------------
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [63:0] RESET_VECTOR = 64'h0,
   parameter int          FQ_DEPTH     = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc_addr,
   input  logic [ILEN-1:0] instruction,
   input  logic            exc_en,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_val,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_instr,
   output logic            out_exc_en,
   output logic [3:0]      out_exc_code,
   output logic [XLEN-1:0] out_exc_val,
   output logic            fetch_halted
);

   fetch_state_t state;
   fetch_state_t state_next;

   logic [XLEN-1:0]           pc;
   logic                      fetch_run;
   logic                      enq;
   logic                      deq;
   fetch_entry_t              new_entry;
   fetch_entry_t              head_entry;
   fetch_entry_t              head_vis;
   logic [$clog2(FQ_DEPTH):0] q_count;
   logic                      q_full;
   logic                      q_empty;

   // Entry formation. A misaligned PC never reaches memory semantically, so
   // it takes priority over whatever exception the memory reports.
   always_comb begin
      new_entry    = '0;
      new_entry.pc = pc;
      if (is_misaligned(pc)) begin
         new_entry.instr    = NOP_INSTR;
         new_entry.exc_en   = 1'b1;
         new_entry.exc_code = EXC_INSTR_MISALIGNED;
         new_entry.exc_val  = pc;
      end else if (exc_en) begin
         new_entry.instr    = NOP_INSTR;
         new_entry.exc_en   = 1'b1;
         new_entry.exc_code = exc_code;
         new_entry.exc_val  = exc_val;
      end else begin
         new_entry.instr    = instruction;
      end
   end

   // Handshake and enqueue decision. A full queue still accepts a new entry
   // when the head is consumed in the same cycle; redirect blocks enqueue.
   always_comb begin
      deq = out_valid && out_ready;
      enq = fetch_run && (!q_full || deq) && !redirect_en;
   end

   // PC register: reset beats redirect, redirect beats sequential advance.
   // An exception entry leaves the PC on the faulting address.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_VECTOR;
      end else if (redirect_en) begin
         pc <= redirect_pc;
      end else if (enq && !new_entry.exc_en) begin
         pc <= pc + 64'd4;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: redirect is the only way out of HALT; enqueuing an
   // exception entry is the only way in.
   always_comb begin
      state_next = state;
      if (redirect_en) begin
         state_next = ST_RUN;
      end else if (state == ST_RUN && enq && new_entry.exc_en) begin
         state_next = ST_HALT;
      end
   end

   // FSM outputs.
   always_comb begin
      fetch_run    = (state == ST_RUN);
      fetch_halted = (state == ST_HALT);
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (enq),
      .push_data (new_entry),
      .pop       (deq),
      .flush     (redirect_en),
      .head_data (head_entry),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   // Stale storage is hidden so the head fields read as zero when empty.
   always_comb begin
      head_vis = q_empty ? fetch_entry_t'('0) : head_entry;
   end

   assign pc_addr      = pc;
   assign out_valid    = (q_count != '0);
   assign out_pc       = head_vis.pc;
   assign out_instr    = head_vis.instr;
   assign out_exc_en   = head_vis.exc_en;
   assign out_exc_code = head_vis.exc_code;
   assign out_exc_val  = head_vis.exc_val;

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
// Self-checking bench for ifetch_unit: a directed vector table followed by a
// randomized phase compared against a queue-based reference model. The
// instruction memory is modelled combinationally from pc_addr.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

   localparam logic [63:0] RV    = 64'h0;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_addr;
   logic [31:0] instruction;
   logic        exc_en;
   logic [3:0]  exc_code;
   logic [63:0] exc_val;
   logic        redirect_en;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_exc_en;
   logic [3:0]  out_exc_code;
   logic [63:0] out_exc_val;
   logic        fetch_halted;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ifetch_unit #(
      .RESET_VECTOR (RV),
      .FQ_DEPTH     (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_addr      (pc_addr),
      .instruction  (instruction),
      .exc_en       (exc_en),
      .exc_code     (exc_code),
      .exc_val      (exc_val),
      .redirect_en  (redirect_en),
      .redirect_pc  (redirect_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .out_exc_en   (out_exc_en),
      .out_exc_code (out_exc_code),
      .out_exc_val  (out_exc_val),
      .fetch_halted (fetch_halted)
   );

   // Memory map: [0x4000, 0xFFFF_FFFF_FFFF_F000) faults, and so does any
   // misaligned address (so misalignment priority is observable via the code).
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a == 64'h0) ? 32'h0050_0093 : {a[19:0], 12'h013};
   endfunction

   function automatic logic mem_fault(input logic [63:0] a);
      return (a >= 64'h4000 && a < 64'hFFFF_FFFF_FFFF_F000) || (a[1:0] != 2'b00);
   endfunction

   assign instruction = mem_word(pc_addr);
   assign exc_en      = mem_fault(pc_addr);
   assign exc_code    = mem_fault(pc_addr) ? 4'd1 : 4'hA;
   assign exc_val     = mem_fault(pc_addr) ? pc_addr : 64'hBAD0;

   // Reference model: PC, halted flag and a plain queue of entries.
   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        exc;
      logic [3:0]  code;
      logic [63:0] val;
   } m_entry_t;

   logic [63:0] m_pc;
   bit          m_halt;
   m_entry_t    m_q[$];

   task automatic model_step(input bit r, input bit d, input logic [63:0] rp, input bit y);
      int       sz;
      bit       take;
      m_entry_t e;
      sz   = m_q.size();
      take = (sz > 0) && y;
      if (r) begin
         m_pc = RV;
         m_q.delete();
         m_halt = 0;
      end else if (d) begin
         m_q.delete();
         m_pc = rp;
         m_halt = 0;
      end else begin
         if (take) void'(m_q.pop_front());
         if (!m_halt && (sz < DEPTH || take)) begin
            if (m_pc[1:0] != 2'b00)  e = '{m_pc, NOP, 1'b1, 4'd0, m_pc};
            else if (mem_fault(m_pc)) e = '{m_pc, NOP, 1'b1, 4'd1, m_pc};
            else                      e = '{m_pc, mem_word(m_pc), 1'b0, 4'd0, 64'd0};
            m_q.push_back(e);
            if (e.exc) m_halt = 1;
            else       m_pc = m_pc + 64'd4;
         end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit d, input logic [63:0] rp, input bit y);
      rst         = r;
      redirect_en = d;
      redirect_pc = rp;
      out_ready   = y;
   endtask

   task automatic checkOutput(input string name, input logic [199:0] got, input logic [199:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [164:0] dut_head();
      return {out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val};
   endfunction

   // Directed vector table.
   typedef struct {
      bit          r;
      bit          d;
      logic [63:0] rp;
      bit          y;
      bit          chk;
      bit          zero;
      logic [63:0] pca;
      bit          v;
      logic [63:0] opc;
      logic [31:0] ins;
      bit          exc;
      logic [3:0]  code;
      logic [63:0] val;
      bit          h;
   } vec_t;

   vec_t rows[$];

   task automatic add(input bit r, d, input logic [63:0] rp, input bit y, chk, zero,
                      input logic [63:0] pca, input bit v, input logic [63:0] opc,
                      input logic [31:0] ins, input bit exc, input logic [3:0] code,
                      input logic [63:0] val, input bit h);
      vec_t t;
      t = '{r, d, rp, y, chk, zero, pca, v, opc, ins, exc, code, val, h};
      rows.push_back(t);
   endtask

   // Shorthand for a plain (non-exception) valid head row.
   task automatic addv(input bit d, input logic [63:0] rp, input bit y,
                       input logic [63:0] pca, input logic [63:0] opc, input bit h);
      add(0, d, rp, y, 1, 0, pca, 1, opc, mem_word(opc), 0, 4'd0, 64'd0, h);
   endtask

   task automatic adde(input bit d, input logic [63:0] rp, input bit y,
                       input logic [63:0] pca, input bit h);
      add(0, d, rp, y, 1, 0, pca, 0, 64'd0, 32'd0, 0, 4'd0, 64'd0, h);
   endtask

   initial begin
      applyStimulus(1, 0, 64'd0, 1);

      // Reset then free-running fetch.
      add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 1, 64'h0, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 1, 64'h4, 64'h0, 0);
      addv(0, 0, 1, 64'h8, 64'h4, 0);
      add(1, 0, 0, 0, 1, 0, 64'hC, 1, 64'h8, mem_word(64'h8), 0, 0, 0, 0);
      // Backpressure: six cycles of out_ready=0 after reset.
      add(0, 0, 0, 0, 1, 1, 64'h0, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 64'h4, 64'h0, 0);
      for (int i = 0; i < 4; i++) addv(0, 0, 0, 64'h8, 64'h0, 0);
      addv(0, 0, 1, 64'h8, 64'h0, 0);
      addv(0, 0, 1, 64'hC, 64'h4, 0);
      addv(0, 0, 0, 64'h10, 64'h8, 0);
      // Redirect while full.
      addv(1, 64'h100, 0, 64'h10, 64'h8, 0);
      adde(0, 0, 0, 64'h100, 0);
      addv(0, 0, 0, 64'h104, 64'h100, 0);
      addv(0, 0, 1, 64'h108, 64'h100, 0);
      // Redirect into the faulting region with a same-cycle dequeue.
      addv(1, 64'h4000, 1, 64'h10C, 64'h104, 0);
      adde(0, 0, 0, 64'h4000, 0);
      add(0, 0, 0, 0, 1, 0, 64'h4000, 1, 64'h4000, NOP, 1, 4'd1, 64'h4000, 1);
      add(0, 0, 0, 1, 1, 0, 64'h4000, 1, 64'h4000, NOP, 1, 4'd1, 64'h4000, 1);
      adde(0, 0, 0, 64'h4000, 1);
      adde(1, 64'h0, 1, 64'h4000, 1);
      adde(0, 0, 1, 64'h0, 0);
      // Misaligned redirect drops the pending entry.
      addv(1, 64'h102, 0, 64'h4, 64'h0, 0);
      adde(0, 0, 0, 64'h102, 0);
      add(0, 1, 64'h3FFC, 0, 1, 0, 64'h102, 1, 64'h102, NOP, 1, 4'd0, 64'h102, 1);
      // Two entries queued and halted, then reset together with redirect.
      adde(0, 0, 0, 64'h3FFC, 0);
      addv(0, 0, 0, 64'h4000, 64'h3FFC, 0);
      add(1, 1, 64'h200, 0, 1, 0, 64'h4000, 1, 64'h3FFC, mem_word(64'h3FFC), 0, 0, 0, 1);
      add(0, 0, 0, 1, 1, 1, 64'h0, 0, 0, 0, 0, 0, 0, 0);
      // 64-bit PC wrap-around.
      addv(1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'h4, 64'h0, 0);
      adde(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      addv(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      addv(0, 0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      addv(0, 0, 1, 64'h4, 64'h0, 0);

      $display("[TB] directed phase: %0d vectors", rows.size());
      for (int i = 0; i < rows.size(); i++) begin
         vec_t t;
         t = rows[i];
         @(negedge clk);
         if (t.chk) begin
            checkOutput($sformatf("row%0d pc_addr", i), pc_addr, t.pca);
            checkOutput($sformatf("row%0d out_valid", i), out_valid, t.v);
            checkOutput($sformatf("row%0d fetch_halted", i), fetch_halted, t.h);
            if (t.v || t.zero)
               checkOutput($sformatf("row%0d head", i), dut_head(),
                           {t.opc, t.ins, t.exc, t.code, t.val});
         end
         applyStimulus(t.r, t.d, t.rp, t.y);
         model_step(t.r, t.d, t.rp, t.y);
      end

      $display("[TB] random phase");
      for (int c = 0; c < 600; c++) begin
         bit          r, d, y;
         logic [63:0] rp;
         int          k;
         @(negedge clk);
         checkOutput($sformatf("rnd%0d pc_addr", c), pc_addr, m_pc);
         checkOutput($sformatf("rnd%0d out_valid", c), out_valid, m_q.size() > 0);
         checkOutput($sformatf("rnd%0d fetch_halted", c), fetch_halted, m_halt);
         if (m_q.size() > 0)
            checkOutput($sformatf("rnd%0d head", c), dut_head(),
                        {m_q[0].pc, m_q[0].instr, m_q[0].exc, m_q[0].code, m_q[0].val});
         r = ($urandom_range(0, 49) == 0);
         d = ($urandom_range(0, 9) == 0);
         y = ($urandom_range(0, 9) < 7);
         k = $urandom_range(0, 9);
         case (k)
            6:       rp = (64'($urandom_range(0, 4095)) << 2) | 64'($urandom_range(1, 3));
            7:       rp = 64'h4000 + (64'($urandom_range(0, 255)) << 2);
            8:       rp = 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(0, 3)) << 2);
            9:       rp = 64'h3FF8;
            default: rp = 64'($urandom_range(0, 4095)) << 2;
         endcase
         applyStimulus(r, d, rp, y);
         model_step(r, d, rp, y);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
